// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
// The optional BIN2BCD_SATURATE_EN build clamps inputs above MAX_DECIMAL.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int NUM_DIGITS  = 4;
  localparam int SCRATCH_W   = BCD_DIGIT_W * NUM_DIGITS;
  localparam int MAX_DECIMAL = 9999;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake plus held BCD digits for the seven-segment driver.
// master = the port logic requesting conversions, slave = the converter.
interface bin2bcd_seq_if #(
  parameter int BIN_WIDTH = 14
);

  logic                 start;
  logic [BIN_WIDTH-1:0] bin_in;
  logic                 busy;
  logic                 done;
  logic [3:0]           digit0;
  logic [3:0]           digit1;
  logic [3:0]           digit2;
  logic [3:0]           digit3;
  logic                 overflow;

  modport master (
    output start, bin_in,
    input  busy, done, digit0, digit1, digit2, digit3, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, digit0, digit1, digit2, digit3, overflow
  );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit corrector: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SATURATE_EN to clamp inputs above 9999 and report overflow.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_WIDTH = 14
) (
  input  logic          clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [SCRATCH_W-1:0] scr_q, scr_d, scr_adj;
  logic [SCRATCH_W-1:0] dig_q, dig_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BIN_WIDTH-1:0] load_val;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scr_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (scr_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BIN2BCD_SATURATE_EN
  logic load_clamp;
  logic ovf_pend_q, ovf_pend_d;
  logic ovf_q, ovf_d;

  always_comb begin
    load_clamp = (32'(bus.bin_in) > 32'(MAX_DECIMAL));
    load_val   = load_clamp ? BIN_WIDTH'(MAX_DECIMAL) : bus.bin_in;
  end
`else
  always_comb load_val = bus.bin_in;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    dig_d   = dig_q;
    done_d  = 1'b0;
`ifdef BIN2BCD_SATURATE_EN
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          bin_d   = load_val;
          scr_d   = '0;
          cnt_d   = CNT_W'(BIN_WIDTH);
`ifdef BIN2BCD_SATURATE_EN
          ovf_pend_d = load_clamp;
`endif
        end
      end
      ST_SHIFT: begin
        // The bit shifted out of digit3 is the 10000s carry and is dropped.
        {scr_d, bin_d} = {scr_adj[SCRATCH_W-2:0], bin_q, 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        dig_d   = scr_q;
        done_d  = 1'b1;
`ifdef BIN2BCD_SATURATE_EN
        ovf_d = ovf_pend_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      dig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIN2BCD_SATURATE_EN
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      dig_q   <= dig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BIN2BCD_SATURATE_EN
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.digit0 = dig_q[3:0];
  assign bus.digit1 = dig_q[7:4];
  assign bus.digit2 = dig_q[11:8];
  assign bus.digit3 = dig_q[15:12];
`ifdef BIN2BCD_SATURATE_EN
  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule
